cmd_proc: RTL and testbench

CMD_PROC -- requirements
Module: cmd_proc

---
 rtl/nav_pkg.sv | 26 ++
 rtl/cmd_proc.sv | 127 ++++++++++++
 tb/tb_cmd_proc.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nav_pkg.sv
// Shared navigation definitions: command-processor states, opcodes and
// response bytes, reused by the maze solver and verification.
package nav_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAL  = 3'd1,
    HDNG = 3'd2,
    MV   = 3'd3,
    SOLV = 3'd4
  } cmd_state_t;

  // Opcode lives in cmd[15:13]; values 3'b100..3'b111 are illegal.
  localparam logic [2:0] OP_CAL   = 3'b000;
  localparam logic [2:0] OP_HDNG  = 3'b001;
  localparam logic [2:0] OP_MV    = 3'b010;
  localparam logic [2:0] OP_SOLVE = 3'b011;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/cmd_proc.sv
// UART command processor: decodes 16-bit commands, launches calibration,
// heading changes, moves or the maze solver, and reports completion.
module cmd_proc
  import nav_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  input  logic        mv_cmplt,
  output logic        strt_solve,
  output logic        cmd_md,
  input  logic        sol_cmplt,
  output logic        send_resp,
  output logic [7:0]  resp,
  output logic        busy
);

  cmd_state_t state, nxt_state;
  logic [2:0] opc;
  logic       ld_hdng;
  logic       ld_mv;
  logic [7:0] resp_val;
  logic [7:0] resp_q;
  logic       unused_cmd_bit;

  assign opc            = cmd[15:13];
  assign unused_cmd_bit = cmd[12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dsrd_hdng <= 12'h000;
      stp_lft   <= 1'b0;
      stp_rght  <= 1'b0;
      resp_q    <= 8'h00;
    end else begin
      state <= nxt_state;
      if (ld_hdng) dsrd_hdng <= cmd[11:0];
      if (ld_mv) begin
        stp_lft  <= cmd[1];
        stp_rght <= cmd[0];
      end
      if (send_resp) resp_q <= resp_val;
    end
  end

  // Pulses are gated by rst so nothing escapes while reset is held.
  always_comb begin
    nxt_state   = state;
    clr_cmd_rdy = 1'b0;
    strt_cal    = 1'b0;
    strt_hdng   = 1'b0;
    strt_mv     = 1'b0;
    strt_solve  = 1'b0;
    send_resp   = 1'b0;
    resp_val    = RESP_ACK;
    ld_hdng     = 1'b0;
    ld_mv       = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (cmd_rdy) begin
            clr_cmd_rdy = 1'b1;
            if (op_is_legal(opc)) begin
              case (opc)
                OP_CAL: begin
                  strt_cal  = 1'b1;
                  nxt_state = CAL;
                end
                OP_HDNG: begin
                  strt_hdng = 1'b1;
                  ld_hdng   = 1'b1;
                  nxt_state = HDNG;
                end
                OP_MV: begin
                  strt_mv   = 1'b1;
                  ld_mv     = 1'b1;
                  nxt_state = MV;
                end
                default: begin
                  strt_solve = 1'b1;
                  nxt_state  = SOLV;
                end
              endcase
            end else begin
              send_resp = 1'b1;
              resp_val  = RESP_ERR;
            end
          end
        end
        CAL: begin
          if (cal_done) begin
            send_resp = 1'b1;
            nxt_state = IDLE;
          end
        end
        HDNG, MV: begin
          if (mv_cmplt) begin
            send_resp = 1'b1;
            nxt_state = IDLE;
          end
        end
        SOLV: begin
          if (sol_cmplt) begin
            send_resp = 1'b1;
            nxt_state = IDLE;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  assign resp   = send_resp ? resp_val : resp_q;
  assign busy   = (state != IDLE);
  assign cmd_md = (state != SOLV);

endmodule

// File: tb/tb_cmd_proc.sv
// Randomized scoreboard bench for cmd_proc with a behavioural reference model.
module tb_cmd_proc;
  import nav_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = 16'h0000;
  logic        cmd_rdy = 1'b0;
  logic        cal_done = 1'b0, mv_cmplt = 1'b0, sol_cmplt = 1'b0;
  logic        clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, strt_solve;
  logic        stp_lft, stp_rght, cmd_md, send_resp, busy;
  logic [11:0] dsrd_hdng;
  logic [7:0]  resp;

  cmd_proc dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .strt_cal(strt_cal), .cal_done(cal_done), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .stp_lft(stp_lft), .stp_rght(stp_rght), .dsrd_hdng(dsrd_hdng), .mv_cmplt(mv_cmplt),
    .strt_solve(strt_solve), .cmd_md(cmd_md), .sol_cmplt(sol_cmplt),
    .send_resp(send_resp), .resp(resp), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic       clr;
    logic       s_cal, s_hdng, s_mv, s_solve;
    logic       snd;
    logic [7:0] rsp;
  } ev_t;

  ev_t exp_q[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit running = 0;

  // Reference model: which completion input (0 cal_done, 1 mv_cmplt,
  // 2 sol_cmplt) the block is waiting on, or -1 when free for commands.
  int          m_wait = -1;
  bit          m_solving = 0;
  logic [11:0] m_hdng = 12'h000;
  logic        m_sl = 1'b0, m_sr = 1'b0;
  bit          pend = 0;
  logic [15:0] pend_cmd = 16'h0000;

  bit          exp_rst = 1;
  bit          exp_busy = 0, exp_md = 1;
  logic [11:0] exp_hdng = 12'h000;
  logic        exp_sl = 1'b0, exp_sr = 1'b0;

  task automatic step(input bit r, input bit nreq, input logic [15:0] c,
                      input bit cd, input bit mc, input bit sc);
    ev_t e;
    logic [2:0] comp;
    if (nreq && !pend) begin
      pend = 1;
      pend_cmd = c;
    end
    rst       = r;
    cmd_rdy   = pend;
    cmd       = pend ? pend_cmd : 16'($urandom);
    cal_done  = cd;
    mv_cmplt  = mc;
    sol_cmplt = sc;
    cyc++;
    if (r) begin
      m_wait = -1;
      m_solving = 0;
      m_hdng = 12'h000;
      m_sl = 1'b0;
      m_sr = 1'b0;
    end
    exp_rst  = r;
    exp_busy = (m_wait >= 0);
    exp_md   = !m_solving;
    exp_hdng = m_hdng;
    exp_sl   = m_sl;
    exp_sr   = m_sr;
    e = '0;
    e.cyc = cyc;
    if (!r) begin
      comp = {sc, mc, cd};
      if (m_wait >= 0) begin
        if (comp[m_wait]) begin
          e.snd = 1'b1;
          e.rsp = RESP_ACK;
          m_wait = -1;
          m_solving = 0;
        end
      end else if (pend) begin
        e.clr = 1'b1;
        pend = 0;
        case (pend_cmd[15:13])
          3'd0: begin e.s_cal = 1'b1; m_wait = 0; end
          3'd1: begin e.s_hdng = 1'b1; m_wait = 1; m_hdng = pend_cmd[11:0]; end
          3'd2: begin e.s_mv = 1'b1; m_wait = 1; m_sl = pend_cmd[1]; m_sr = pend_cmd[0]; end
          3'd3: begin e.s_solve = 1'b1; m_wait = 2; m_solving = 1; end
          default: begin e.snd = 1'b1; e.rsp = RESP_ERR; end
        endcase
      end
    end
    if (e.clr || e.snd || e.s_cal || e.s_hdng || e.s_mv || e.s_solve)
      exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0000, 0, 0, 0);
  endtask

  function automatic void note(input bit ok, input string msg);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s", msg);
  endfunction

  always @(negedge clk) begin
    ev_t a, x;
    if (running && cyc > 0) begin
      note(busy === exp_busy && cmd_md === exp_md && dsrd_hdng === exp_hdng &&
           stp_lft === exp_sl && stp_rght === exp_sr,
           $sformatf("levels cyc=%0d got busy=%b cmd_md=%b hdng=%h stp=%b%b want busy=%b cmd_md=%b hdng=%h stp=%b%b",
                     cyc, busy, cmd_md, dsrd_hdng, stp_lft, stp_rght,
                     exp_busy, exp_md, exp_hdng, exp_sl, exp_sr));
      if (exp_rst)
        note(resp === 8'h00 && !clr_cmd_rdy && !send_resp,
             $sformatf("reset_out cyc=%0d got resp=%h clr=%b snd=%b want 00/0/0",
                       cyc, resp, clr_cmd_rdy, send_resp));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        x = exp_q.pop_front();
        note(0, $sformatf("missed_event got none want %p", x));
      end
      a = '0;
      a.cyc = cyc;
      a.clr = clr_cmd_rdy;
      a.s_cal = strt_cal;
      a.s_hdng = strt_hdng;
      a.s_mv = strt_mv;
      a.s_solve = strt_solve;
      a.snd = send_resp;
      a.rsp = send_resp ? resp : 8'h00;
      if (a.clr || a.snd || a.s_cal || a.s_hdng || a.s_mv || a.s_solve) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          x = exp_q.pop_front();
          note(a == x, $sformatf("event cyc=%0d got %p want %p", cyc, a, x));
        end else begin
          note(0, $sformatf("unexpected_event cyc=%0d got %p want none", cyc, a));
        end
      end
    end
  end

  initial begin
    int rst_left;
    logic [15:0] c;
    @(posedge clk);
    #1;
    running = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0000, 0, 0, 0);

    // Heading change then completion
    step(0, 1, 16'h23FF, 0, 0, 0);
    idle(3);
    step(0, 0, 16'h0000, 0, 1, 0);
    idle(2);

    // Move with a second command queued until mv_cmplt
    step(0, 1, 16'h4002, 0, 0, 0);
    idle(2);
    step(0, 1, 16'h0000, 0, 0, 0);
    idle(3);
    step(0, 0, 16'h0000, 0, 1, 0);
    idle(3);
    step(0, 0, 16'h0000, 1, 0, 0);
    idle(1);

    // Illegal opcode
    step(0, 1, 16'hE000, 0, 0, 0);
    idle(2);

    // Solver ownership; foreign completions ignored
    step(0, 1, 16'h6000, 0, 0, 0);
    idle(2);
    step(0, 0, 16'h0000, 0, 1, 0);
    step(0, 0, 16'h0000, 1, 0, 0);
    idle(1);
    step(0, 0, 16'h0000, 0, 0, 1);
    idle(2);

    // Reset during calibration
    step(0, 1, 16'h0000, 0, 0, 0);
    idle(2);
    step(1, 0, 16'h0000, 0, 0, 0);
    step(1, 0, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0000, 1, 0, 0);
    idle(1);
    step(0, 1, 16'h0000, 0, 0, 0);
    idle(1);
    step(0, 0, 16'h0000, 1, 0, 0);
    idle(2);

    // Random traffic
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 2);
      c = 16'($urandom);
      c[15:13] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      step(rst_left > 0, $urandom_range(0, 3) == 0, c,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      if (rst_left > 0) rst_left--;
    end
    idle(2);

    @(negedge clk);
    running = 0;
    note(exp_q.size() == 0, $sformatf("drain got %0d pending events want 0", exp_q.size()));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
